// File: rtl/vid_colour_box_detector.sv
// Colour-window detector for the clocked-video stream.
// Counts pixels whose RGB value falls inside a programmable window, tracks
// their bounding box over a frame and publishes both on the next frame edge.
// Video is passed through with one cycle of latency, optionally with the
// previous frame's box outline drawn over it.
module vid_colour_box_detector #(
    parameter int          IMG_W      = 640,
    parameter int          IMG_H      = 480,
    parameter int          MIN_PIXELS = 16,
    parameter logic [23:0] BOX_COLOUR = 24'hFF0000
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [23:0] vid_data,
    input  logic        vid_datavalid,
    input  logic        vid_h_sync,
    input  logic        vid_v_sync,
    input  logic [7:0]  r_min,
    input  logic [7:0]  r_max,
    input  logic [7:0]  g_min,
    input  logic [7:0]  g_max,
    input  logic [7:0]  b_min,
    input  logic [7:0]  b_max,
    input  logic        overlay_en,
    output logic [23:0] out_vid_data,
    output logic        out_datavalid,
    output logic        out_h_sync,
    output logic        out_v_sync,
    output logic [9:0]  box_x_min,
    output logic [9:0]  box_x_max,
    output logic [8:0]  box_y_min,
    output logic [8:0]  box_y_max,
    output logic [18:0] pix_count,
    output logic        box_valid,
    output logic        frame_done
);

    localparam logic [9:0]  X_LAST  = 10'(IMG_W - 1);
    localparam logic [8:0]  Y_LAST  = 9'(IMG_H - 1);
    localparam logic [18:0] CNT_MAX = 19'h7FFFF;
    localparam logic [18:0] MIN_PIX = 19'(MIN_PIXELS);

    // Inclusive range test; an inverted window (lo > hi) never matches.
    function automatic logic in_range(input logic [7:0] v, input logic [7:0] lo,
                                      input logic [7:0] hi);
        in_range = (v >= lo) && (v <= hi);
    endfunction

    // Sync-edge history and frame state
    logic        v_sync_d_r;
    logic        dv_d_r;
    logic        armed_r;
    logic [9:0]  x_r;
    logic [8:0]  y_r;

    // Threshold shadows, valid for the current frame
    logic [7:0]  th_r_min_r, th_r_max_r, th_g_min_r, th_g_max_r, th_b_min_r, th_b_max_r;

    // Per-frame accumulators
    logic [18:0] acc_count_r;
    logic [9:0]  acc_x_min_r, acc_x_max_r;
    logic [8:0]  acc_y_min_r, acc_y_max_r;

    // Combinational helpers
    logic        v_rise_s;
    logic        dv_fall_s;
    logic [9:0]  pix_x_s;
    logic [8:0]  pix_y_s;
    logic [9:0]  x_next_s;
    logic [8:0]  y_next_s;
    logic [7:0]  eff_r_min_s, eff_r_max_s, eff_g_min_s, eff_g_max_s, eff_b_min_s, eff_b_max_s;
    logic        match_s;
    logic [18:0] base_count_s, next_count_s;
    logic [9:0]  base_x_min_s, base_x_max_s, next_x_min_s, next_x_max_s;
    logic [8:0]  base_y_min_s, base_y_max_s, next_y_min_s, next_y_max_s;
    logic        in_box_x_s, in_box_y_s, on_perim_s, overlay_s;
    logic        latch_s;
    logic        result_valid_s;

    assign v_rise_s  = vid_v_sync & ~v_sync_d_r;
    assign dv_fall_s = dv_d_r & ~vid_datavalid;
    assign latch_s   = v_rise_s & armed_r;

    // Coordinates of the current pixel: a pixel coincident with v_rise is the new frame's (0,0)
    always_comb begin
        if (v_rise_s) begin
            pix_x_s = 10'd0;
            pix_y_s = 9'd0;
        end else begin
            pix_x_s = x_r;
            pix_y_s = y_r;
        end
    end

    // Next coordinates: advance x per pixel, new line on datavalid fall, both saturate
    always_comb begin
        x_next_s = pix_x_s;
        y_next_s = pix_y_s;
        if (vid_datavalid) begin
            x_next_s = (pix_x_s == X_LAST) ? pix_x_s : pix_x_s + 10'd1;
        end else if (dv_fall_s && !v_rise_s) begin
            x_next_s = 10'd0;
            y_next_s = (y_r == Y_LAST) ? y_r : y_r + 9'd1;
        end else begin
            x_next_s = pix_x_s;
            y_next_s = pix_y_s;
        end
    end

    // Thresholds in force for this pixel: the new frame's values apply on the v_rise cycle itself
    always_comb begin
        if (v_rise_s) begin
            eff_r_min_s = r_min;      eff_r_max_s = r_max;
            eff_g_min_s = g_min;      eff_g_max_s = g_max;
            eff_b_min_s = b_min;      eff_b_max_s = b_max;
        end else begin
            eff_r_min_s = th_r_min_r; eff_r_max_s = th_r_max_r;
            eff_g_min_s = th_g_min_r; eff_g_max_s = th_g_max_r;
            eff_b_min_s = th_b_min_r; eff_b_max_s = th_b_max_r;
        end
    end

    assign match_s = vid_datavalid & (armed_r | v_rise_s)
                   & in_range(vid_data[23:16], eff_r_min_s, eff_r_max_s)
                   & in_range(vid_data[15:8],  eff_g_min_s, eff_g_max_s)
                   & in_range(vid_data[7:0],   eff_b_min_s, eff_b_max_s);

    // Accumulator update: start from cleared values on a frame edge, then fold in a match
    always_comb begin
        if (v_rise_s) begin
            base_count_s = 19'd0;
            base_x_min_s = X_LAST;
            base_x_max_s = 10'd0;
            base_y_min_s = Y_LAST;
            base_y_max_s = 9'd0;
        end else begin
            base_count_s = acc_count_r;
            base_x_min_s = acc_x_min_r;
            base_x_max_s = acc_x_max_r;
            base_y_min_s = acc_y_min_r;
            base_y_max_s = acc_y_max_r;
        end
        next_count_s = base_count_s;
        next_x_min_s = base_x_min_s;
        next_x_max_s = base_x_max_s;
        next_y_min_s = base_y_min_s;
        next_y_max_s = base_y_max_s;
        if (match_s) begin
            next_count_s = (base_count_s == CNT_MAX) ? base_count_s : base_count_s + 19'd1;
            next_x_min_s = (pix_x_s < base_x_min_s) ? pix_x_s : base_x_min_s;
            next_x_max_s = (pix_x_s > base_x_max_s) ? pix_x_s : base_x_max_s;
            next_y_min_s = (pix_y_s < base_y_min_s) ? pix_y_s : base_y_min_s;
            next_y_max_s = (pix_y_s > base_y_max_s) ? pix_y_s : base_y_max_s;
        end else begin
            next_count_s = base_count_s;
        end
    end

    assign result_valid_s = (acc_count_r >= MIN_PIX);

    // Outline test against the box latched from the previous frame
    always_comb begin
        in_box_x_s = (pix_x_s >= box_x_min) && (pix_x_s <= box_x_max);
        in_box_y_s = (pix_y_s >= box_y_min) && (pix_y_s <= box_y_max);
        on_perim_s = (in_box_x_s && ((pix_y_s == box_y_min) || (pix_y_s == box_y_max)))
                   || (in_box_y_s && ((pix_x_s == box_x_min) || (pix_x_s == box_x_max)));
        overlay_s  = overlay_en & box_valid & vid_datavalid & on_perim_s;
    end

    // Edge history, armed flag, coordinates and threshold shadows
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            v_sync_d_r <= 1'b0;
            dv_d_r     <= 1'b0;
            armed_r    <= 1'b0;
            x_r        <= 10'd0;
            y_r        <= 9'd0;
            th_r_min_r <= 8'd0; th_r_max_r <= 8'd0;
            th_g_min_r <= 8'd0; th_g_max_r <= 8'd0;
            th_b_min_r <= 8'd0; th_b_max_r <= 8'd0;
        end else begin
            v_sync_d_r <= vid_v_sync;
            dv_d_r     <= vid_datavalid;
            x_r        <= x_next_s;
            y_r        <= y_next_s;
            if (v_rise_s) begin
                armed_r    <= 1'b1;
                th_r_min_r <= r_min; th_r_max_r <= r_max;
                th_g_min_r <= g_min; th_g_max_r <= g_max;
                th_b_min_r <= b_min; th_b_max_r <= b_max;
            end
        end
    end

    // Per-frame accumulators
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            acc_count_r <= 19'd0;
            acc_x_min_r <= X_LAST;
            acc_x_max_r <= 10'd0;
            acc_y_min_r <= Y_LAST;
            acc_y_max_r <= 9'd0;
        end else begin
            acc_count_r <= next_count_s;
            acc_x_min_r <= next_x_min_s;
            acc_x_max_r <= next_x_max_s;
            acc_y_min_r <= next_y_min_s;
            acc_y_max_r <= next_y_max_s;
        end
    end

    // Publish the finished frame's results on an armed frame edge
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            frame_done <= 1'b0;
            pix_count  <= 19'd0;
            box_valid  <= 1'b0;
            box_x_min  <= 10'd0;
            box_x_max  <= 10'd0;
            box_y_min  <= 9'd0;
            box_y_max  <= 9'd0;
        end else if (latch_s) begin
            frame_done <= 1'b1;
            pix_count  <= acc_count_r;
            box_valid  <= result_valid_s;
            box_x_min  <= result_valid_s ? acc_x_min_r : 10'd0;
            box_x_max  <= result_valid_s ? acc_x_max_r : 10'd0;
            box_y_min  <= result_valid_s ? acc_y_min_r : 9'd0;
            box_y_max  <= result_valid_s ? acc_y_max_r : 9'd0;
        end else begin
            frame_done <= 1'b0;
        end
    end

    // One-cycle video pass-through with optional outline
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            out_vid_data  <= 24'd0;
            out_datavalid <= 1'b0;
            out_h_sync    <= 1'b0;
            out_v_sync    <= 1'b0;
        end else begin
            out_vid_data  <= overlay_s ? BOX_COLOUR : vid_data;
            out_datavalid <= vid_datavalid;
            out_h_sync    <= vid_h_sync;
            out_v_sync    <= vid_v_sync;
        end
    end

endmodule

// File: tb/tb_vid_colour_box_detector.sv
// Directed bench for vid_colour_box_detector: a table of frame records with
// hand-computed results, plus hand-written reset and overlay sequences.
module tb_vid_colour_box_detector;

    localparam logic [23:0] RED  = 24'hF01010;
    localparam logic [23:0] GREY = 24'h202020;
    localparam int K_BOX = 0;
    localparam int K_TEN = 1;
    localparam int K_SAT = 2;
    localparam int K_NONE = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] vid_data = 24'd0;
    logic        vid_datavalid = 1'b0;
    logic        vid_h_sync = 1'b0;
    logic        vid_v_sync = 1'b0;
    logic [7:0]  r_min = 8'd0, r_max = 8'd255, g_min = 8'd0, g_max = 8'd255;
    logic [7:0]  b_min = 8'd0, b_max = 8'd255;
    logic        overlay_en = 1'b0;
    logic [23:0] out_vid_data;
    logic        out_datavalid, out_h_sync, out_v_sync;
    logic [9:0]  box_x_min, box_x_max;
    logic [8:0]  box_y_min, box_y_max;
    logic [18:0] pix_count;
    logic        box_valid, frame_done;

    int errors = 0;
    int checks = 0;
    int fd_pulses = 0;

    vid_colour_box_detector dut (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .vid_data(vid_data), .vid_datavalid(vid_datavalid),
        .vid_h_sync(vid_h_sync), .vid_v_sync(vid_v_sync),
        .r_min(r_min), .r_max(r_max), .g_min(g_min), .g_max(g_max),
        .b_min(b_min), .b_max(b_max), .overlay_en(overlay_en),
        .out_vid_data(out_vid_data), .out_datavalid(out_datavalid),
        .out_h_sync(out_h_sync), .out_v_sync(out_v_sync),
        .box_x_min(box_x_min), .box_x_max(box_x_max),
        .box_y_min(box_y_min), .box_y_max(box_y_max),
        .pix_count(pix_count), .box_valid(box_valid), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_pulses = fd_pulses + 1;
    end

    typedef struct {
        int         kind;
        logic [7:0] rmn, rmx, gmn, gmx, bmn, bmx;
        bit         keep;
        bit         kill;
        int         cnt, xmn, xmx, ymn, ymx;
        bit         vld;
    } vec_t;

    vec_t vecs[7];
    vec_t prev;

    function automatic vec_t mk(int kind, int rmn, int rmx, int gmn, int gmx, int bmn,
                                int bmx, bit keep, bit kill, int cnt, int xmn, int xmx,
                                int ymn, int ymx, bit vld);
        vec_t v;
        v.kind = kind;
        v.rmn = 8'(rmn); v.rmx = 8'(rmx); v.gmn = 8'(gmn);
        v.gmx = 8'(gmx); v.bmn = 8'(bmn); v.bmx = 8'(bmx);
        v.keep = keep; v.kill = kill;
        v.cnt = cnt; v.xmn = xmn; v.xmx = xmx; v.ymn = ymn; v.ymx = ymx;
        v.vld = vld;
        return v;
    endfunction

    function automatic bit on_perim(int x, int y);
        return ((x >= 100 && x <= 149) && (y == 50 || y == 89)) ||
               ((y >= 50 && y <= 89) && (x == 100 || x == 149));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_results(input vec_t e);
        chk("pix_count", 32'(pix_count), 32'(e.cnt));
        chk("box_valid", 32'(box_valid), 32'(e.vld));
        chk("box_x_min", 32'(box_x_min), 32'(e.xmn));
        chk("box_x_max", 32'(box_x_max), 32'(e.xmx));
        chk("box_y_min", 32'(box_y_min), 32'(e.ymn));
        chk("box_y_max", 32'(box_y_max), 32'(e.ymx));
    endtask

    task automatic set_th(input vec_t v);
        r_min = v.rmn; r_max = v.rmx; g_min = v.gmn;
        g_max = v.gmx; b_min = v.bmn; b_max = v.bmx;
    endtask

    // One v_sync pulse; returns frame_done as seen in the cycle after v_rise
    task automatic frame_edge(output bit fd);
        vid_v_sync = 1'b1; vid_datavalid = 1'b0; vid_h_sync = 1'b0; vid_data = 24'd0;
        step();
        fd = frame_done;
        chk("out_v_sync_hi", 32'(out_v_sync), 32'd1);
        vid_v_sync = 1'b0;
        step();
        chk("frame_done_pulse_end", 32'(frame_done), 32'd0);
        chk("out_v_sync_lo", 32'(out_v_sync), 32'd0);
    endtask

    task automatic send_pixel(input logic [23:0] d, input bit ovl, input int x, input int y);
        vid_datavalid = 1'b1; vid_data = d; vid_h_sync = 1'b0;
        step();
        if (ovl) begin
            chk("ovl_data", 32'(out_vid_data), 32'(on_perim(x, y) ? 24'hFF0000 : d));
            chk("ovl_dv", 32'(out_datavalid), 32'd1);
            chk("ovl_hs", 32'(out_h_sync), 32'd0);
        end
    endtask

    task automatic end_line(input bit ovl);
        vid_datavalid = 1'b0; vid_data = 24'd0; vid_h_sync = 1'b1;
        step();
        if (ovl) begin
            chk("blank_dv", 32'(out_datavalid), 32'd0);
            chk("blank_hs", 32'(out_h_sync), 32'd1);
            chk("blank_data", 32'(out_vid_data), 32'd0);
        end
        vid_h_sync = 1'b0;
    endtask

    // Rows 0..49 one grey pixel; rows 50..90 160 wide, red block x100..149 y50..89
    task automatic send_box_frame(input bit ovl, input bit kill);
        for (int y = 0; y <= 90; y++) begin
            if (kill && y == 60) begin
                r_min = 8'd0; r_max = 8'd0;
            end
            for (int x = 0; x < ((y < 50) ? 1 : 160); x++) begin
                send_pixel((y >= 50 && y <= 89 && x >= 100 && x <= 149) ? RED : GREY,
                           ovl, x, y);
            end
            end_line(ovl);
        end
    endtask

    task automatic send_line(input int n, input int lo, input int hi);
        for (int x = 0; x < n; x++) send_pixel((x >= lo && x <= hi) ? RED : GREY, 1'b0, x, 0);
        end_line(1'b0);
    endtask

    task automatic send_4x4();
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 4; x++) send_pixel(GREY, 1'b0, x, y);
            end_line(1'b0);
        end
    endtask

    initial begin
        bit   fd;
        int   base;
        vec_t e4;

        vecs[0] = mk(K_BOX, 200, 255, 0, 40, 0, 40, 0, 0, 2000, 100, 149, 50, 89, 1);
        vecs[1] = mk(K_TEN, 200, 255, 0, 40, 0, 40, 0, 0, 10, 0, 0, 0, 0, 0);
        vecs[2] = mk(K_BOX, 200, 100, 0, 40, 0, 40, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[3] = mk(K_SAT, 200, 255, 0, 40, 0, 40, 0, 0, 16, 639, 639, 0, 0, 1);
        vecs[4] = mk(K_BOX, 200, 255, 0, 40, 0, 40, 0, 1, 2000, 100, 149, 50, 89, 1);
        vecs[5] = mk(K_BOX, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        vecs[6] = mk(K_BOX, 200, 255, 0, 40, 0, 40, 0, 0, 2000, 100, 149, 50, 89, 1);
        e4 = mk(K_NONE, 0, 255, 0, 255, 0, 255, 0, 0, 16, 0, 3, 0, 3, 1);

        // Reset: drive busy inputs, all outputs must stay 0
        vid_data = 24'hAAAAAA; vid_datavalid = 1'b1; vid_h_sync = 1'b1; vid_v_sync = 1'b1;
        step(); step();
        chk("rst_out_data", 32'(out_vid_data), 32'd0);
        chk("rst_out_dv", 32'(out_datavalid), 32'd0);
        chk("rst_out_hs", 32'(out_h_sync), 32'd0);
        chk("rst_out_vs", 32'(out_v_sync), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        check_results(mk(K_NONE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vid_data = 24'd0; vid_datavalid = 1'b0; vid_h_sync = 1'b0; vid_v_sync = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        base = fd_pulses;

        // Arm, start a frame, reset in the middle of it
        frame_edge(fd);
        chk("first_edge_no_done", 32'(fd), 32'd0);
        send_pixel(GREY, 1'b0, 0, 0);
        send_pixel(GREY, 1'b0, 1, 0);
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        send_pixel(GREY, 1'b0, 2, 0);
        end_line(1'b0);
        send_4x4();
        frame_edge(fd);
        chk("edge1_no_done", 32'(fd), 32'd0);
        chk("edge1_pix_count", 32'(pix_count), 32'd0);
        send_4x4();
        frame_edge(fd);
        chk("edge2_done", 32'(fd), 32'd1);
        check_results(e4);
        send_4x4();
        frame_edge(fd);
        chk("edge3_done", 32'(fd), 32'd1);
        check_results(e4);
        chk("done_pulses", 32'(fd_pulses - base), 32'd2);

        // Table-driven frames; each edge publishes the previous record's frame
        prev = mk(K_NONE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 7; k++) begin
            if (!vecs[k].keep) set_th(vecs[k]);
            frame_edge(fd);
            chk("tbl_frame_done", 32'(fd), 32'd1);
            check_results(prev);
            case (vecs[k].kind)
                K_BOX:   send_box_frame(1'b0, vecs[k].kill);
                K_TEN:   send_line(20, 5, 14);
                K_SAT:   send_line(700, 684, 699);
                default: ;
            endcase
            prev = vecs[k];
        end

        // Overlay frame using the box latched from the last table frame
        overlay_en = 1'b1;
        frame_edge(fd);
        chk("ovl_pre_done", 32'(fd), 32'd1);
        check_results(prev);
        send_box_frame(1'b1, 1'b0);
        frame_edge(fd);
        chk("ovl_post_done", 32'(fd), 32'd1);
        check_results(vecs[6]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
